// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with redirect, trap vector and return-address stack
module pc_unit #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned INSTR_BYTES = 4,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC = 'h100,
  parameter int unsigned RAS_DEPTH = 4,
  localparam int unsigned PW = $clog2(RAS_DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            fetch_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            call,
  input  logic            ret,
  input  logic            trap,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic            misalign,
  output logic            ret_miss,
  output logic [CW-1:0]   ras_count,
  output logic            ras_overflow
);
  localparam logic [XLEN-1:0] LOW = XLEN'(INSTR_BYTES - 1);
  logic [XLEN-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]   ptr;
  logic [XLEN-1:0] seq, top, pc_next;
  logic            fire, do_push, do_pop, empty, full, pop_hit;
  // next-PC selection in priority order: trap, redirect, return, sequential, hold
  always_comb begin
    seq = pc_out + XLEN'(INSTR_BYTES);
    top = ras[ptr - PW'(1)];
    fire = pc_valid & fetch_ready & ~stall;
    empty = ras_count == '0;
    full = ras_count == CW'(RAS_DEPTH);
    do_push = ~trap & redirect_valid & call;
    do_pop = ~trap & ~redirect_valid & ret & fire;
    pop_hit = do_pop & ~empty;
    pc_next = trap ? TRAP_VEC
            : redirect_valid ? (redirect_target & ~LOW)
            : pop_hit ? top
            : (do_pop | fire) ? seq
            : pc_out;
  end
  // PC, status pulses and stack bookkeeping; ptr marks the next free slot so a full push overwrites the oldest entry
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out <= RESET_VEC;
      pc_valid <= 1'b0;
      misalign <= 1'b0;
      ret_miss <= 1'b0;
      ras_count <= '0;
      ras_overflow <= 1'b0;
      ptr <= '0;
    end else begin
      pc_out <= pc_next;
      pc_valid <= 1'b1;
      misalign <= ~trap & redirect_valid & |(redirect_target & LOW);
      ret_miss <= do_pop & empty;
      ras_count <= trap ? '0
                 : do_push ? (full ? ras_count : ras_count + CW'(1))
                 : pop_hit ? ras_count - CW'(1)
                 : ras_count;
      ras_overflow <= ras_overflow | (do_push & full);
      ptr <= do_push ? ptr + PW'(1) : pop_hit ? ptr - PW'(1) : ptr;
    end
  end
  // return-address storage needs no reset; entries are only read while counted valid
  always_ff @(posedge clk) begin
    if (!reset && do_push) ras[ptr] <= seq;
  end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: randomized and directed checks of pc_unit against a queue-based model
module tb_pc_unit;
  logic clk = 1'b0;
  logic reset = 1'b1, stall = 1'b0, fetch_ready = 1'b0, redirect_valid = 1'b0;
  logic call = 1'b0, ret = 1'b0, trap = 1'b0;
  logic [63:0] redirect_target = '0;
  logic [63:0] pc_out;
  logic pc_valid, misalign, ret_miss, ras_overflow;
  logic [2:0] ras_count;
  int total = 0, bad = 0;
  logic [63:0] m_pc;
  logic m_valid, m_mis, m_miss, m_ovf;
  logic [2:0] m_cnt;
  logic [63:0] q [$];
  wire [70:0] obs = {pc_out, pc_valid, misalign, ret_miss, ras_count, ras_overflow};
  wire [70:0] expv = {m_pc, m_valid, m_mis, m_miss, m_cnt, m_ovf};

  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .fetch_ready(fetch_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .call(call), .ret(ret), .trap(trap), .pc_out(pc_out), .pc_valid(pc_valid),
    .misalign(misalign), .ret_miss(ret_miss), .ras_count(ras_count),
    .ras_overflow(ras_overflow)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    logic f;
    logic [63:0] s;
    f = m_valid && fetch_ready && !stall;
    s = m_pc + 64'd4;
    m_mis = 1'b0;
    m_miss = 1'b0;
    if (reset) begin
      m_pc = '0; m_valid = 1'b0; m_ovf = 1'b0; q.delete();
    end else begin
      if (trap) begin
        m_pc = 64'h100; q.delete();
      end else if (redirect_valid) begin
        if (call) begin
          q.push_back(s);
          if (q.size() > 4) begin void'(q.pop_front()); m_ovf = 1'b1; end
        end
        m_mis = redirect_target[1:0] != 2'b00;
        m_pc = {redirect_target[63:2], 2'b00};
      end else if (ret && f) begin
        if (q.size() == 0) begin m_pc = s; m_miss = 1'b1; end
        else m_pc = q.pop_back();
      end else if (f) m_pc = s;
      m_valid = 1'b1;
    end
    m_cnt = 3'(q.size());
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; fetch_ready = 1; redirect_valid = 0; call = 0; ret = 0; trap = 0; reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; cycle(); cycle();
    total++; if (obs !== expv || pc_out !== 64'h0 || pc_valid !== 1'b0) begin bad++; $display("FAIL reset: got %h want %h", obs, expv); end
    reset = 0; fetch_ready = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      total++; if (obs !== expv || pc_out !== 64'(4 * i) || pc_valid !== 1'b1) begin bad++; $display("FAIL seq%0d: got %h want %h pc_exp %0d", i, obs, expv, 4 * i); end
    end
  endtask

  task automatic test_stall();
    cycle();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++; if (obs !== expv || pc_out !== 64'h10) begin bad++; $display("FAIL stall_hold: got %h want pc 10 model %h", obs, expv); end
    end
    stall = 0; cycle();
    total++; if (obs !== expv || pc_out !== 64'h14) begin bad++; $display("FAIL stall_release: got %h want pc 14", pc_out); end
    fetch_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++; if (obs !== expv || pc_out !== 64'h14) begin bad++; $display("FAIL notready_hold: got %h want pc 14", pc_out); end
    end
    fetch_ready = 1; cycle();
    total++; if (obs !== expv || pc_out !== 64'h18) begin bad++; $display("FAIL ready_release: got %h want pc 18", pc_out); end
  endtask

  task automatic test_misalign();
    stall = 1; redirect_valid = 1; redirect_target = 64'h203; cycle();
    redirect_valid = 0;
    total++; if (obs !== expv || pc_out !== 64'h200 || misalign !== 1'b1) begin bad++; $display("FAIL misalign_set: got %h want %h", obs, expv); end
    cycle();
    total++; if (obs !== expv || pc_out !== 64'h200 || misalign !== 1'b0) begin bad++; $display("FAIL misalign_pulse: got %h want %h", obs, expv); end
    stall = 0;
  endtask

  task automatic test_call_ret();
    redirect_valid = 1; redirect_target = 64'h40; cycle();
    call = 1; redirect_target = 64'h800; cycle();
    call = 0; redirect_valid = 0;
    total++; if (obs !== expv || pc_out !== 64'h800 || ras_count !== 3'd1) begin bad++; $display("FAIL call_push: got %h want %h", obs, expv); end
    cycle(); cycle();
    ret = 1; cycle(); ret = 0;
    total++; if (obs !== expv || pc_out !== 64'h44 || ras_count !== 3'd0) begin bad++; $display("FAIL ret_pop: got %h want %h", obs, expv); end
  endtask

  task automatic test_overflow();
    redirect_valid = 1; call = 1;
    for (int i = 0; i < 5; i++) begin redirect_target = 64'h1000 * (i + 1); cycle(); end
    redirect_valid = 0; call = 0;
    total++; if (obs !== expv || ras_overflow !== 1'b1 || ras_count !== 3'd4) begin bad++; $display("FAIL overflow: got %h want %h", obs, expv); end
    ret = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      total++; if (obs !== expv || pc_out !== 64'h4004 - 64'h1000 * i) begin bad++; $display("FAIL lifo%0d: got %h want %h", i, pc_out, 64'h4004 - 64'h1000 * i); end
    end
    cycle(); ret = 0;
    total++; if (obs !== expv || ret_miss !== 1'b1 || pc_out !== 64'h1008) begin bad++; $display("FAIL ret_empty: got %h want %h", obs, expv); end
    cycle();
    total++; if (obs !== expv || ret_miss !== 1'b0 || ras_overflow !== 1'b1) begin bad++; $display("FAIL ret_miss_pulse: got %h want %h", obs, expv); end
  endtask

  task automatic test_trap();
    redirect_valid = 1; call = 1; redirect_target = 64'h2000; cycle();
    redirect_target = 64'h3000; cycle();
    call = 0; redirect_valid = 0;
    total++; if (obs !== expv || ras_count !== 3'd2) begin bad++; $display("FAIL trap_setup: got %h want %h", obs, expv); end
    trap = 1; redirect_valid = 1; redirect_target = 64'h303; ret = 1; cycle();
    trap = 0; redirect_valid = 0; ret = 0;
    total++; if (obs !== expv || pc_out !== 64'h100 || ras_count !== 3'd0 || ret_miss !== 1'b0 || misalign !== 1'b0 || ras_overflow !== 1'b1) begin bad++; $display("FAIL trap: got %h want %h", obs, expv); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1; redirect_target = 64'hFFFF_FFFF_FFFF_FFFC; cycle();
    redirect_valid = 0;
    total++; if (obs !== expv || pc_out !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_setup: got %h want %h", obs, expv); end
    cycle();
    total++; if (obs !== expv || pc_out !== 64'h0) begin bad++; $display("FAIL wrap: got %h want 0", pc_out); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = $urandom_range(0, 63) == 0;
      stall = $urandom_range(0, 3) == 0;
      fetch_ready = $urandom_range(0, 4) != 0;
      redirect_valid = $urandom_range(0, 4) == 0;
      redirect_target = {$urandom, $urandom};
      call = $urandom_range(0, 1) == 0;
      ret = $urandom_range(0, 2) == 0;
      trap = $urandom_range(0, 31) == 0;
      cycle();
      total++; if (obs !== expv) begin bad++; $display("FAIL random%0d: got %h want %h", i, obs, expv); end
    end
    idle();
  endtask

  initial begin
    m_pc = '0; m_valid = 0; m_mis = 0; m_miss = 0; m_ovf = 0; m_cnt = '0;
    test_reset();
    test_stall();
    test_misalign();
    test_call_ret();
    test_overflow();
    test_trap();
    test_wrap();
    test_random();
    reset = 1; redirect_valid = 1; trap = 1; call = 1; cycle();
    total++; if (obs !== expv || pc_out !== 64'h0 || pc_valid !== 1'b0 || ras_overflow !== 1'b0) begin bad++; $display("FAIL midreset: got %h want %h", obs, expv); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
